// File: rtl/pong_pkg.sv
// Shared screen geometry, object placement, colours and game-state type for the Pong pixel stage.
package pong_pkg;

    localparam logic [9:0] SCR_W    = 10'd640;
    localparam logic [9:0] SCR_H    = 10'd480;
    localparam logic [9:0] REFR_ROW = 10'd481;

    localparam logic [9:0] PAD_L_X0 = 10'd32;
    localparam logic [9:0] PAD_L_X1 = 10'd35;
    localparam logic [9:0] PAD_R_X0 = 10'd600;
    localparam logic [9:0] PAD_R_X1 = 10'd603;

    localparam logic [9:0] BALL_X0  = 10'd316;
    localparam logic [9:0] BALL_Y0  = 10'd236;

    localparam logic [9:0] NET_X0   = 10'd318;
    localparam logic [9:0] NET_X1   = 10'd321;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_BALL  = 12'hF00;
    localparam logic [11:0] COL_PAD   = 12'hFFF;
    localparam logic [11:0] COL_NET   = 12'h888;

    typedef enum logic [1:0] {SERVE, PLAY, OVER} game_st_t;

    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_pixel_gen_if.sv
// Pixel-stage bundle: timing-controller coordinates and buttons in, colour, scores and miss pulse out.
interface pong_pixel_gen_if;

    logic       p_tick;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       up_l;
    logic       dn_l;
    logic       up_r;
    logic       dn_r;
    logic [11:0] rgb;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       miss;

    modport master (
        output p_tick, video_on, x, y, up_l, dn_l, up_r, dn_r,
        input  rgb, score_l, score_r, miss
    );

    modport slave (
        input  p_tick, video_on, x, y, up_l, dn_l, up_r, dn_r,
        output rgb, score_l, score_r, miss
    );

endinterface

// File: rtl/pong_paddle.sv
// Paddle top-row register: steps PAD_V per frame tick while exactly one button is held, clamped on screen.
// New position is visible one clock after refr; freeze holds it, no backpressure.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PAD_V = 3,
    parameter int PAD_H = 72
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       refr,
    input  logic       up,
    input  logic       dn,
    input  logic       freeze,
    output logic [9:0] pad_y
);

    localparam logic [9:0] STEP   = 10'(PAD_V);
    localparam logic [9:0] Y_MAX  = SCR_H - 10'(PAD_H);
    localparam logic [9:0] Y_INIT = Y_MAX / 10'd2;

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            pad_y <= Y_INIT;
        end else if (refr && !freeze) begin
            if (up && !dn) begin
                pad_y <= (pad_y >= STEP) ? pad_y - STEP : 10'd0;
            end else if (dn && !up) begin
                pad_y <= (pad_y <= Y_MAX - STEP) ? pad_y + STEP : Y_MAX;
            end
        end
    end

endmodule

// File: rtl/pong_pixel_gen.sv
// Pong game state (ball, paddles, scores, serve/play/over) advanced once per frame, plus a registered pixel mux.
// rgb loads 1 clk after each p_tick; no backpressure. Define PONG_ROUND_BALL_EN to draw a round 8x8 ball.
module pong_pixel_gen
    import pong_pkg::*;
#(
    parameter int BALL_V       = 2,
    parameter int PAD_V        = 3,
    parameter int PAD_H        = 72,
    parameter int BALL_SZ      = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input logic             clk_100MHz,
    input logic             reset,
    pong_pixel_gen_if.slave bus
);

    localparam logic [9:0] BV  = 10'(BALL_V);
    localparam logic [9:0] BSZ = 10'(BALL_SZ);
    localparam logic [9:0] PH  = 10'(PAD_H);
    localparam int         CW  = $clog2(SERVE_FRAMES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    game_st_t      st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    bx, by, bx_n, by_n;
    logic          dx, dy, dx_n, dy_n;
    logic [3:0]    sl, sr, sl_n, sr_n;
    logic          miss_q, miss_n;
    logic [11:0]   rgb_q, pix;

    logic       refr, frz, any_btn;
    logic [9:0] pad_l, pad_r, ball_r;
    logic       ovl_l, ovl_r, hit_l, hit_r, out_l, out_r;

    assign refr    = bus.p_tick && (bus.y == REFR_ROW) && (bus.x == 10'd0);
    assign frz     = (st == OVER);
    assign any_btn = bus.up_l | bus.dn_l | bus.up_r | bus.dn_r;

    pong_paddle #(.PAD_V(PAD_V), .PAD_H(PAD_H)) u_pad_l (
        .clk_100MHz(clk_100MHz), .reset(reset), .refr(refr),
        .up(bus.up_l), .dn(bus.dn_l), .freeze(frz), .pad_y(pad_l)
    );

    pong_paddle #(.PAD_V(PAD_V), .PAD_H(PAD_H)) u_pad_r (
        .clk_100MHz(clk_100MHz), .reset(reset), .refr(refr),
        .up(bus.up_r), .dn(bus.dn_r), .freeze(frz), .pad_y(pad_r)
    );

    // Collision and miss tests use the pre-move ball and current paddle positions.
    assign ball_r = bx + BSZ - 10'd1;
    assign ovl_l  = (by < pad_l + PH) && (by + BSZ > pad_l);
    assign ovl_r  = (by < pad_r + PH) && (by + BSZ > pad_r);
    assign hit_r  = dx && in_span(ball_r, PAD_R_X0, PAD_R_X1 + BV) && ovl_r;
    assign hit_l  = !dx && in_span(bx, PAD_L_X0 - BV, PAD_L_X1) && ovl_l;
    assign out_r  = dx && !hit_r && (bx + BSZ >= SCR_W - BV);
    assign out_l  = !dx && !hit_l && (bx <= BV);

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        bx_n   = bx;
        by_n   = by;
        dx_n   = dx;
        dy_n   = dy;
        sl_n   = sl;
        sr_n   = sr;
        miss_n = 1'b0;
        if (refr) begin
            case (st)
                SERVE: begin
                    if (cnt == CNT_LAST) begin
                        st_n  = PLAY;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PLAY: begin
                    if (by <= BV)
                        dy_n = 1'b1;
                    else if (by + BSZ >= SCR_H - BV)
                        dy_n = 1'b0;
                    if (hit_r)
                        dx_n = 1'b0;
                    else if (hit_l)
                        dx_n = 1'b1;
                    if (out_r || out_l) begin
                        miss_n = 1'b1;
                        bx_n   = BALL_X0;
                        by_n   = BALL_Y0;
                        dx_n   = out_r;
                        cnt_n  = '0;
                        st_n   = SERVE;
                        if (out_r) begin
                            sl_n = (sl == WIN) ? sl : sl + 4'd1;
                            if (sl_n == WIN) st_n = OVER;
                        end else begin
                            sr_n = (sr == WIN) ? sr : sr + 4'd1;
                            if (sr_n == WIN) st_n = OVER;
                        end
                    end else begin
                        bx_n = dx_n ? bx + BV : bx - BV;
                        by_n = dy_n ? by + BV : by - BV;
                    end
                end
                OVER: begin
                    if (any_btn) begin
                        sl_n  = 4'd0;
                        sr_n  = 4'd0;
                        cnt_n = '0;
                        st_n  = SERVE;
                    end
                end
                default: st_n = SERVE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            st     <= SERVE;
            cnt    <= '0;
            bx     <= BALL_X0;
            by     <= BALL_Y0;
            dx     <= 1'b1;
            dy     <= 1'b1;
            sl     <= 4'd0;
            sr     <= 4'd0;
            miss_q <= 1'b0;
        end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            bx     <= bx_n;
            by     <= by_n;
            dx     <= dx_n;
            dy     <= dy_n;
            sl     <= sl_n;
            sr     <= sr_n;
            miss_q <= miss_n;
        end
    end

    logic ball_box, ball_on, pad_on, net_on;

    assign ball_box = (st != OVER) && (bus.x >= bx) && (bus.x < bx + BSZ)
                   && (bus.y >= by) && (bus.y < by + BSZ);

`ifdef PONG_ROUND_BALL_EN
    localparam logic [7:0] BALL_ROM [0:7] = '{
        8'b00111100, 8'b01111110, 8'b11111111, 8'b11111111,
        8'b11111111, 8'b11111111, 8'b01111110, 8'b00111100
    };
    logic [2:0] rom_row, rom_col;
    assign rom_row = 3'(bus.y - by);
    assign rom_col = 3'(bus.x - bx);
    assign ball_on = ball_box && BALL_ROM[rom_row][3'd7 - rom_col];
`else
    assign ball_on = ball_box;
`endif

    assign pad_on = (in_span(bus.x, PAD_L_X0, PAD_L_X1) && (bus.y >= pad_l) && (bus.y < pad_l + PH))
                 || (in_span(bus.x, PAD_R_X0, PAD_R_X1) && (bus.y >= pad_r) && (bus.y < pad_r + PH));
    assign net_on = in_span(bus.x, NET_X0, NET_X1) && !bus.y[4];

    always_comb begin
        pix = COL_BLACK;
        if (!bus.video_on)
            pix = COL_BLACK;
        else if (ball_on)
            pix = COL_BALL;
        else if (pad_on)
            pix = COL_PAD;
        else if (net_on)
            pix = COL_NET;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset)
            rgb_q <= COL_BLACK;
        else if (bus.p_tick)
            rgb_q <= pix;
    end

    assign bus.rgb     = rgb_q;
    assign bus.miss    = miss_q;
    assign bus.score_l = sl;
    assign bus.score_r = sr;

endmodule
